imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_word_asm.sv | 51 +++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CSUM_EN adds the CSUM state; encodings stay fixed either way.
package imem_loader_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 64;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian byte-to-word assembler: the first byte of a word ends up in word[7:0].
// word_ready pulses for one cycle after the byte that completes a word.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        ready_q, ready_d;

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ready_d   = 1'b0;
        last_byte = (cnt_q == 2'(BYTES_PER_WORD - 1));
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (byte_valid) begin
            // Shift right so earlier bytes drift toward the low lanes.
            shift_d = {byte_data, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            ready_d = last_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
        end
    end

    assign word_ready = ready_q;
    assign word       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a header/data(/checksum) byte sequence into instruction memory while holding
// the CPU in reset. Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both high;
// rx_ready depends only on the current state, never on rx_valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [31:0]   wd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_reset,
    output logic [2:0]    dbg_state
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state_q, state_d;
    logic [7:0]    n_q, n_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cpu_reset_q, cpu_reset_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          accept;
    logic          data_take;
    logic          asm_clear;
    logic          word_ready;
    logic          last_byte;
    logic          last_word;
    logic          hdr_bad;
    logic [31:0]   asm_word;

    always_comb begin
        rx_ready = (state_q == HDR) || (state_q == DATA)
`ifdef IMEM_LOADER_CSUM_EN
                   || (state_q == CSUM)
`endif
                   ;
    end

    assign accept    = rx_valid && rx_ready;
    assign data_take = accept && (state_q == DATA);
    assign last_word = (32'(idx_q) == (32'(n_q) - 32'd1));
    assign hdr_bad   = (rx_data == 8'd0) || (32'(rx_data) > DEPTH);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        asm_clear = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d    = csum_q;
`endif
        // The final word's pulse lands after DATA is left, so the index stops at N-1.
        if (word_ready && (state_q == DATA)) begin
            idx_d = idx_q + IW'(1);
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = HDR;
                    idx_d     = '0;
                    asm_clear = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            HDR: begin
                if (accept) begin
                    n_d     = rx_data;
                    state_d = hdr_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d = csum_q ^ rx_data;
                    if (last_byte && last_word) begin
                        state_d = CSUM;
                    end
`else
                    if (last_byte && last_word) begin
                        state_d = DONE;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= 8'd0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    imem_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (data_take),
        .byte_data  (rx_data),
        .word_ready (word_ready),
        .word       (asm_word),
        .last_byte  (last_byte)
    );

    assign we        = word_ready;
    assign wa        = AW'({idx_q, 2'b00});
    assign wd        = asm_word;
    assign busy      = rx_ready;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_reset = cpu_reset_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: a stream model queues the expected writes and final
// status; a negedge monitor pops and compares each we pulse.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_reset;
    logic [2:0]    dbg_state;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  data_bytes [0:255];

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_reset (cpu_reset),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checkers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_we: wa=0x%0h wd=0x%0h, expected no write", wa, wd);
                end else begin
                    e = exp_q.pop_front();
                    check32("write_wa", wa, e[63:32]);
                    check32("write_wd", wd, e[31:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("start_done_cleared", done, 1'b0);
        check1("start_err_cleared", err, 1'b0);
        check1("start_cpu_reset", cpu_reset, 1'b1);
        check1("start_busy", busy, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall_pct, input logic with_start);
        int waited;
        waited = 0;
        @(negedge clk);
        start = 1'b0;
        while (int'($urandom_range(99, 0)) < stall_pct) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: rx_ready=0 after %0d cycles, expected 1", waited);
            rx_valid = 1'b0;
            start    = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < 4 * n; k++) data_bytes[k] = 8'($urandom_range(255, 0));
    endtask

    // Reference model: the header decides acceptance, each group of four bytes is one
    // little-endian word at byte address 4*i, and the checksum is the XOR of the data bytes.
    task automatic run_load(input int n, input int csum_byte, input int stall_pct, input int start_at);
        logic [7:0]  x;
        logic [7:0]  cb;
        logic        bad;
        logic        exp_done;
        logic [31:0] w;
        x   = 8'd0;
        bad = (n == 0) || (n > DEPTH);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                w = {data_bytes[4*i+3], data_bytes[4*i+2], data_bytes[4*i+1], data_bytes[4*i]};
                exp_q.push_back({32'(i * 4), w});
                for (int j = 0; j < 4; j++) x = x ^ data_bytes[4*i+j];
            end
        end
        cb = (csum_byte < 0) ? x : 8'(csum_byte);
`ifdef IMEM_LOADER_CSUM_EN
        exp_done = !bad && (cb == x);
`else
        exp_done = !bad;
`endif
        do_start();
        send_byte(8'(n), stall_pct, 1'b0);
        if (!bad) begin
            for (int k = 0; k < 4 * n; k++) send_byte(data_bytes[k], stall_pct, k == start_at);
`ifdef IMEM_LOADER_CSUM_EN
            send_byte(cb, stall_pct, 1'b0);
`endif
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check32("writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check1("end_done", done, exp_done);
        check1("end_err", err, !exp_done);
        check1("end_cpu_reset", cpu_reset, !exp_done);
        check1("end_busy", busy, 1'b0);
        check1("end_rx_ready", rx_ready, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_we"}, we, 1'b0);
        check32({tag, "_wa"}, wa, 32'd0);
        check32({tag, "_wd"}, wd, 32'd0);
        check1({tag, "_rx_ready"}, rx_ready, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] vec [0:7];
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Two real RV32I instructions; their bytes XOR to 0x10.
        vec = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
        for (int k = 0; k < 8; k++) data_bytes[k] = vec[k];
        run_load(2, -1, 0, -1);
        run_load(2, 8'h33, 0, -1);

        // Bad headers.
        run_load(0, -1, 0, -1);
        run_load(65, -1, 0, -1);

        // Full depth with heavy stalls; the last write lands at 0xFC.
        fill_random(64);
        run_load(64, -1, 50, -1);

        // Random sizes, sometimes a corrupted checksum.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(8, 1));
            fill_random(n);
            if ($urandom_range(1, 0) == 0) run_load(n, -1, 25, -1);
            else run_load(n, int'($urandom_range(255, 0)), 25, -1);
        end

        // start pulsed mid-DATA has no effect.
        fill_random(3);
        run_load(3, -1, 10, 5);

        // Reset after five data bytes: one word written, then everything drops.
        fill_random(2);
        exp_q.push_back({32'd0, {data_bytes[3], data_bytes[2], data_bytes[1], data_bytes[0]}});
        do_start();
        send_byte(8'd2, 0, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(data_bytes[k], 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        check32("mid_rst_writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fill_random(1);
        run_load(1, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
